fir_out_collector: RTL
======================

// Module: fir_out_collector
// PURPOSE
//   Receiving end of the FIR output stream: captures every DOUT/VOUT-qualified sample
//   into a circular buffer and exposes it through a read port with a valid strobe.
//   Sits after FIR in place of the behavioural sink, for on-chip capture and readout.
//   Flags overflow and reports fill level.
// PARAMETERS
//   NB     9   sample width, matches the FIR DOUT width
//   DEPTH  16  buffer entries; must be a power of 2
//   AW     4   address width, log2(DEPTH)
// PORTS
//   CLK    in   1     single clock, all state on rising edge
//   RST    in   1     asynchronous, active-high reset
//   VIN    in   1     input sample valid (from FIR VOUT)
//   DIN    in   NB    input sample, two's complement (from FIR DOUT)
//   CLR    in   1     synchronous clear of buffer, flags and signature
//   RD_EN  in   1     read request, one sample per cycle
//   DOUT   out  NB    read data, registered
//   VOUT   out  1     DOUT valid, high for 1 cycle per accepted read
//   COUNT  out  AW+1  occupied entries, 0..DEPTH
//   FULL   out  1     COUNT==DEPTH
//   EMPTY  out  1     COUNT==0
//   OVF    out  1     sticky: a sample was dropped
//   SIG    out  16    signature of accepted samples (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, RST=1): wr_ptr=rd_ptr=0, COUNT=0, DOUT=0, VOUT=0, OVF=0, SIG=0;
//     EMPTY=1, FULL=0. Buffer contents are not reset.
//   - Write accepted = VIN & (~FULL | rd_acc); stores DIN at wr_ptr, wr_ptr+1 mod DEPTH.
//   - Read accepted rd_acc = RD_EN & ~EMPTY. DOUT<=mem[rd_ptr], VOUT<=1 next cycle.
//     rd_ptr+1 mod DEPTH. Latency RD_EN->VOUT is 1 cycle.
//   - RD_EN while EMPTY: ignored; VOUT=0 next cycle, DOUT holds its last value.
//   - VOUT=0 in every cycle following a non-accepted read.
//   - Simultaneous write and read: both happen, COUNT unchanged.
//   - FULL & RD_EN & VIN: the read frees a slot; the write is accepted and OVF is not set.
//   - EMPTY & VIN & RD_EN: write accepted, read ignored (no fall-through); VOUT=0.
//   - VIN & FULL & ~RD_EN: sample dropped, memory/pointers unchanged, OVF<=1 (sticky).
//   - COUNT: +1 on write-only, -1 on read-only, hold otherwise. FULL/EMPTY derive
//     combinationally from COUNT.
//   - Pointer wrap: AW-bit pointers wrap DEPTH-1 -> 0 with no gap.
//   - CLR=1: pointers, COUNT, OVF, SIG <= 0 and VOUT <= 0. CLR wins over VIN/RD_EN in the
//     same cycle; that cycle's input sample is discarded. DOUT holds.
//   - RST mid-stream: everything returns to reset state immediately; any in-flight VOUT
//     drops asynchronously.
// CONFIGURATION
//   FIR_COLLECTOR_SIG_EN defined: on each accepted write,
//     SIG <= {SIG[14:0], SIG[15]^SIG[4]^SIG[2]^SIG[1]} ^ {{(16-NB){1'b0}}, DIN}.
//     Dropped samples do not update SIG; CLR/RST set SIG=0.
//   FIR_COLLECTOR_SIG_EN undefined: no signature logic; the SIG port exists tied to 16'h0000.
// TESTING
//   1 RST=1 then 0, idle -> COUNT=0, EMPTY=1, FULL=0, OVF=0, VOUT=0, DOUT=0.
//   2 VIN=1 for 3 cycles with DIN=9'h001,9'h1FF,9'h0AA, then RD_EN=1 for 3 cycles ->
//     VOUT=1 one cycle after each RD_EN, DOUT=001,1FF,0AA in order; COUNT 3->0, EMPTY=1.
//   3 write 16 samples 0..15 -> FULL=1; 17th VIN with DIN=9'h055 -> OVF=1, COUNT=16;
//     drain all 16 -> reads return 0..15 (9'h055 absent); OVF stays 1 until CLR=1.
//   4 FULL, VIN=1 & RD_EN=1, DIN=9'h123 -> OVF=0, COUNT stays 16; read oldest entry;
//     drain -> 9'h123 is the last sample. EMPTY & VIN & RD_EN -> VOUT=0, COUNT=1.
//   5 wrap: 40 write/read pairs, ramp 0..39 -> all data in order across pointer wrap.
//     CLR mid-stream with VIN=1 -> next cycle COUNT=0, VOUT=0, that sample is lost.
//   6 SIG_EN defined: writes 9'h001, 9'h002 from SIG=0 -> SIG=16'h0001, then 16'h0000;
//     undefined -> SIG=16'h0000 always. Assert RST mid-read -> VOUT=0 at once.

Source files
------------

// File: rtl/fir_out_collector.sv
// fir_out_collector: circular capture buffer for the FIR output stream with a registered read port.
// Define FIR_COLLECTOR_SIG_EN to enable the LFSR-style signature on SIG; otherwise SIG is tied to zero.
module fir_out_collector #(
   parameter int NB    = 9,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          VIN,
   input  logic [NB-1:0] DIN,
   input  logic          CLR,
   input  logic          RD_EN,
   output logic [NB-1:0] DOUT,
   output logic          VOUT,
   output logic [AW:0]   COUNT,
   output logic          FULL,
   output logic          EMPTY,
   output logic          OVF,
   output logic [15:0]   SIG
);
   logic [NB-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [NB-1:0] dout_q, dout_d;
   logic          vout_q, vout_d, ovf_q, ovf_d;
   logic          rd_acc, wr_acc, mem_we;

   assign FULL  = count_q == (AW+1)'(DEPTH);
   assign EMPTY = count_q == '0;
   assign COUNT = count_q;
   assign DOUT  = dout_q;
   assign VOUT  = vout_q;
   assign OVF   = ovf_q;

   // a read in the same cycle frees the slot the write needs, so FULL alone does not drop
   always_comb begin
      rd_acc   = RD_EN & ~EMPTY;
      wr_acc   = VIN & (~FULL | rd_acc);
      mem_we   = ~CLR & wr_acc;
      wr_ptr_d = CLR ? '0 : wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = CLR ? '0 : rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = CLR ? '0 : (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                 (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
      dout_d   = (~CLR & rd_acc) ? mem[rd_ptr_q] : dout_q;
      vout_d   = ~CLR & rd_acc;
      ovf_d    = ~CLR & (ovf_q | (VIN & ~wr_acc));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         vout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         vout_q   <= vout_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge CLK)
      if (mem_we) mem[wr_ptr_q] <= DIN;

`ifdef FIR_COLLECTOR_SIG_EN
   logic [15:0] sig_q, sig_d;

   always_comb
      sig_d = CLR ? '0 : wr_acc ? {sig_q[14:0], sig_q[15] ^ sig_q[4] ^ sig_q[2] ^ sig_q[1]} ^
              {{(16-NB){1'b0}}, DIN} : sig_q;

   always_ff @(posedge CLK or posedge RST)
      if (RST) sig_q <= '0;
      else     sig_q <= sig_d;

   assign SIG = sig_q;
`else
   assign SIG = 16'h0000;
`endif
endmodule
